// File: rtl/sw_fifo_player.sv
// Key-driven record/playback FIFO: key 0 pushes the switch byte, key 1 pops onto the hex display.
// Define KEY_DEBOUNCE_EN to insert a per-key level filter after the synchronizers.
module sw_fifo_player #(
    parameter int DEPTH           = 8,
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic [9:0] sw_i,
    input  logic [1:0] key_i,
    output logic [9:0] ledr_o,
    output logic [6:0] hex0_o,
    output logic [6:0] hex1_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [1:0]        sync1_q, sync2_q, lvl, lvl_hist_q, armed_q, press_q;
    logic [1:0]        settle_q;
    logic [DATA_W-1:0] data_q;
    logic              clr_q;
    logic              unused_sw8;

    assign unused_sw8 = sw_i[8];

    // A key only becomes armed once its synchronized level has been seen released
    // after reset, so a key held down across reset release never counts as a press.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            lvl_hist_q <= 2'b11;
            armed_q    <= 2'b00;
            press_q    <= 2'b00;
            settle_q   <= 2'b00;
            data_q     <= '0;
            clr_q      <= 1'b0;
        end else begin
            sync1_q    <= key_i;
            sync2_q    <= sync1_q;
            lvl_hist_q <= lvl;
            settle_q   <= {settle_q[0], 1'b1};
            armed_q    <= armed_q | ({2{settle_q[1]}} & sync2_q & lvl);
            press_q    <= armed_q & lvl_hist_q & ~lvl;
            data_q     <= sw_i[DATA_W-1:0];
            clr_q      <= sw_i[9];
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] db_cnt_q [2];
    logic [1:0]    filt_q;

    always_ff @(posedge clk100_i) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_i) begin
                db_cnt_q[k] <= '0;
                filt_q[k]   <= 1'b1;
            end else if (sync2_q[k] != filt_q[k]) begin
                if (db_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[k]   <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DW'(1);
                end
            end else begin
                db_cnt_q[k] <= '0;
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] disp_q;
    logic              ovf_q, udf_q;
    logic              push, pop, empty, full, push_ok, pop_ok, ovf_set, udf_set;

    assign push    = press_q[0];
    assign pop     = press_q[1];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO still fits when a pop frees a slot in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign ovf_set = push & ~push_ok;
    assign udf_set = pop & empty;

    always_ff @(posedge clk100_i) begin
        if (!rst_i && push_ok) begin
            mem[wr_ptr_q] <= data_q;
        end
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                disp_q   <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clr_q) begin
                ovf_q <= 1'b0;
            end
            if (udf_set) begin
                udf_q <= 1'b1;
            end else if (clr_q) begin
                udf_q <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign hex1_o = seg7(disp_q[7:4]);
    assign hex0_o = seg7(disp_q[3:0]);
    assign ledr_o = {full, empty, ovf_q, udf_q, 2'b00, 4'(count_q)};

endmodule

// File: tb/tb_sw_fifo_player.sv
// Directed bench for sw_fifo_player: table-driven push/pop vectors plus hand-written
// sequences for reset, simultaneous presses, flag clearing and reset with stored data.
module tb_sw_fifo_player;
    logic       clk100_i = 1'b0;
    logic       rst_i;
    logic [9:0] sw_i;
    logic [1:0] key_i;
    logic [9:0] ledr_o;
    logic [6:0] hex0_o;
    logic [6:0] hex1_o;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_disp;

`ifdef KEY_DEBOUNCE_EN
    localparam int HOLD = 5;
    localparam int LAT  = 7;
    localparam int GAP  = 6;
`else
    localparam int HOLD = 2;
    localparam int LAT  = 3;
    localparam int GAP  = 0;
`endif

    sw_fifo_player dut (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .sw_i     (sw_i),
        .key_i    (key_i),
        .ledr_o   (ledr_o),
        .hex0_o   (hex0_o),
        .hex1_o   (hex1_o)
    );

    // clock / reset block
    always #5 clk100_i = ~clk100_i;

    typedef struct {
        logic [1:0] keys;
        logic [7:0] data;
        logic [9:0] exp_ledr;
        logic [7:0] exp_disp;
    } vec_t;

    vec_t vecs[18];

    logic [6:0] glyph [16];

    task automatic tick(input int n);
        repeat (n) @(posedge clk100_i);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [9:0] e_ledr, input logic [7:0] e_disp);
        check({name, ".ledr"}, {6'd0, ledr_o}, {6'd0, e_ledr});
        check({name, ".hex1"}, {9'd0, hex1_o}, {9'd0, glyph[e_disp[7:4]]});
        check({name, ".hex0"}, {9'd0, hex0_o}, {9'd0, glyph[e_disp[3:0]]});
    endtask

    // driver: hold keys low, release, return just after the edge where the result lands
    task automatic press(input logic [1:0] keys, input logic [7:0] data);
        if (GAP > 0) tick(GAP);
        sw_i  = {2'b00, data};
        key_i = keys;
        tick(HOLD);
        key_i = 2'b11;
        tick(LAT - HOLD + 1);
    endtask

    task automatic clear_flags();
        sw_i = 10'h200;
        tick(2);
        sw_i = 10'h000;
    endtask

    initial begin
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vecs[0]  = '{2'b10, 8'h01, 10'h001, 8'hA5};
        vecs[1]  = '{2'b10, 8'h02, 10'h002, 8'hA5};
        vecs[2]  = '{2'b10, 8'h03, 10'h003, 8'hA5};
        vecs[3]  = '{2'b10, 8'h04, 10'h004, 8'hA5};
        vecs[4]  = '{2'b10, 8'h05, 10'h005, 8'hA5};
        vecs[5]  = '{2'b10, 8'h06, 10'h006, 8'hA5};
        vecs[6]  = '{2'b10, 8'h07, 10'h007, 8'hA5};
        vecs[7]  = '{2'b10, 8'h08, 10'h208, 8'hA5};
        vecs[8]  = '{2'b10, 8'h09, 10'h288, 8'hA5};
        vecs[9]  = '{2'b01, 8'h00, 10'h087, 8'h01};
        vecs[10] = '{2'b01, 8'h00, 10'h086, 8'h02};
        vecs[11] = '{2'b01, 8'h00, 10'h085, 8'h03};
        vecs[12] = '{2'b01, 8'h00, 10'h084, 8'h04};
        vecs[13] = '{2'b01, 8'h00, 10'h083, 8'h05};
        vecs[14] = '{2'b01, 8'h00, 10'h082, 8'h06};
        vecs[15] = '{2'b01, 8'h00, 10'h081, 8'h07};
        vecs[16] = '{2'b01, 8'h00, 10'h180, 8'h08};
        vecs[17] = '{2'b01, 8'h00, 10'h1C0, 8'h08};

        // reset state
        rst_i = 1'b1;
        sw_i  = 10'h000;
        key_i = 2'b11;
        tick(2);
        check_state("reset", 10'h100, 8'h00);

        // key 0 held low through reset release
        key_i = 2'b10;
        tick(2);
        rst_i = 1'b0;
        tick(8);
        check("held_key_no_push", {6'd0, ledr_o}, 16'h0100);
        key_i = 2'b11;
        tick(8);
        check("held_key_release", {6'd0, ledr_o}, 16'h0100);

        // push A5: unchanged one edge early, count 1 on the third edge after the fall
        sw_i  = 10'h0A5;
        key_i = 2'b10;
        tick(HOLD);
        key_i = 2'b11;
        tick(LAT - HOLD);
        check("push_a5_early", {6'd0, ledr_o}, 16'h0100);
        tick(1);
        check("push_a5", {6'd0, ledr_o}, 16'h0001);
        press(2'b01, 8'h00);
        check_state("pop_a5", 10'h100, 8'hA5);

        // nine pushes, eight pops, one underflowing pop
        for (int i = 0; i < 18; i++) begin
            press(vecs[i].keys, vecs[i].data);
            check_state($sformatf("vec%0d", i), vecs[i].exp_ledr, vecs[i].exp_disp);
        end

        // udf clears one edge after sw[9] is registered
        sw_i = 10'h200;
        tick(1);
        check("clr_registered", {6'd0, ledr_o}, 16'h01C0);
        tick(1);
        check("clr_applied", {6'd0, ledr_o}, 16'h0100);
        sw_i = 10'h000;

        // fill, then simultaneous push/pop while full
        for (int i = 0; i < 8; i++) begin
            press(2'b10, 8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        check("fill8", {6'd0, ledr_o}, 16'h0208);
        press(2'b00, 8'h77);
        exp_q.push_back(8'h77);
        exp_disp = exp_q.pop_front();
        check_state("both_full", 10'h208, exp_disp);
        for (int i = 0; i < 8; i++) begin
            press(2'b01, 8'h00);
            exp_disp = exp_q.pop_front();
            check($sformatf("drain%0d.hex", i), {2'd0, hex1_o, hex0_o},
                  {2'd0, glyph[exp_disp[7:4]], glyph[exp_disp[3:0]]});
        end
        check("drained", {6'd0, ledr_o}, 16'h0100);

        // simultaneous push/pop while empty: no bypass
        press(2'b00, 8'h55);
        check_state("both_empty", 10'h041, 8'h77);
        clear_flags();

        // reset with five entries stored, a pop pressed in the reset cycle
        for (int i = 0; i < 4; i++) begin
            press(2'b10, 8'h60 + 8'(i));
        end
        check("five_stored", {6'd0, ledr_o}, 16'h0005);
        key_i = 2'b01;
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        key_i = 2'b11;
        check_state("mid_reset", 10'h100, 8'h00);
        tick(6);
        check("after_reset_idle", {6'd0, ledr_o}, 16'h0100);
        press(2'b01, 8'h00);
        check_state("pop_after_reset", 10'h140, 8'h00);

`ifdef KEY_DEBOUNCE_EN
        clear_flags();
        tick(8);
        sw_i  = 10'h033;
        key_i = 2'b10;
        tick(2);
        key_i = 2'b11;
        tick(12);
        check("glitch_no_push", {6'd0, ledr_o}, 16'h0100);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sw_fifo_player.md
# sw_fifo_player

Board-level record/playback block for the practicum board: each debounced press of key 0 writes the current switch byte into an 8-entry FIFO, and each press of key 1 pops the oldest entry and shows it on the two seven-segment digits. It is the reader/playback counterpart to the key-driven counter, using the same board pins, key polarity and display encoding so both blocks can share one test harness. Status (fill level, full/empty, sticky error flags) is shown on the red LEDs.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `DATA_W`, 8: stored width; fixed at 8 (two hex digits).
- `DEBOUNCE_CYCLES`, 4: stable-level cycles required before a key edge is accepted; used only when `KEY_DEBOUNCE_EN` is defined.
- `clk100_i`, in, 1: system clock; all logic on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `sw_i`, in, 10: `sw_i[7:0]` is the write data; `sw_i[9]` is the sticky-flag clear (level); `sw_i[8]` is unused.
- `key_i`, in, 2: push buttons, active-low (1 = released); `key_i[0]` = push, `key_i[1]` = pop.
- `ledr_o`, out, 10: status LEDs.
- `hex0_o`, out, 7: low nibble of the displayed byte, segments `{g,f,e,d,c,b,a}`, active-low.
- `hex1_o`, out, 7: high nibble of the displayed byte, same encoding.

## Operation
- **Key path:** each `key_i` bit passes through a 2-flop synchronizer, then a history flop. A press is a synchronized 1→0 transition and is a one-cycle pulse. Holding a key produces exactly one press. The release edge does nothing.
- **Switch path:** `sw_i` is registered once every cycle. A push stores the registered `sw_i[7:0]` from the same cycle as the press pulse.
- **Push:**
  - If count < `DEPTH`: write at the write pointer, increment the pointer (wraps modulo `DEPTH`), count += 1.
  - If full: discard the data and set `ovf` (sticky).
- **Pop:**
  - If count > 0: load the entry at the read pointer into the display register, increment the pointer (wraps), count -= 1.
  - If empty: set `udf` (sticky); the display register is unchanged.
- **Simultaneous push and pop pulses, same cycle:**
  - Full: both succeed; count stays `DEPTH`; `ovf` is not set.
  - Empty: the pop underflows (`udf` set, display unchanged); the push succeeds; count becomes 1. There is no bypass.
  - Otherwise: both succeed; count is unchanged.
- **Sticky flags:** cleared on any cycle where registered `sw_i[9]` = 1. A set request in the same cycle wins over the clear.
- **Display register:** 8 bits; `hex1_o` = seg(display[7:4]), `hex0_o` = seg(display[3:0]). Standard active-low glyphs 0–F; for example, 0 = 7'b1000000, A = 7'b0001000, F = 7'b0001110.
- **`ledr_o` map:**
  - [3:0] count (0..`DEPTH`, 4 bits at default `DEPTH`)
  - [5:4] = 0
  - [6] `udf`
  - [7] `ovf`
  - [8] empty
  - [9] full
- **Reset (`rst_i` = 1 at a clock edge):**
  - Pointers, count, flags and display register go to 0; synchronizers load 1 (released). No press is generated by the reset release.
  - Output values: `ledr_o` = 10'b01_0000_0000, `hex0_o` = `hex1_o` = 7'b1000000.
  - Reset dominates any press in the same cycle.
  - Memory contents are not cleared and are unobservable.

## Timing
- A `key_i` fall sampled at edge N gives a press pulse after edge N+2. FIFO state, `ledr_o` and the hex outputs update at edge N+3.
- Outputs are registered or are combinational decodes of registers only; there is no input-to-output combinational path.
- The switch value captured is the one sampled at edge N+2.
- Minimum spacing for distinct presses: 2 cycles low, 2 cycles high (without debounce).
- Reset takes effect at the edge where `rst_i` = 1. Outputs show reset values after that edge.

## Configuration
- `KEY_DEBOUNCE_EN` defined: a per-key counter follows the synchronizer. The filtered level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. The press is the filtered 1→0 transition.
  - Latency becomes N+2+`DEBOUNCE_CYCLES`+1.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no press.
  - Debounce counters clear on reset.
- `KEY_DEBOUNCE_EN` undefined: no filter; timing is as stated in Timing.

## Test plan
- Reset then idle: `ledr_o` = 10'h100, both hex = 7'b1000000; a key held low through the reset release produces no push or pop.
- Push 8'hA5, then pop: after the push, `ledr_o[3:0]` = 1. After the pop, `hex1_o` = 7'b0001000, `hex0_o` = 7'b0010010, `ledr_o` = 10'h100, three cycles after each key fall.
- Push 8'h01..8'h09 (nine pushes): count = 8, `ledr_o[9]` = 1, `ledr_o[7]` = 1. Eight pops display 01..08 in order, then empty; 8'h09 is never shown.
- Pop on empty: `ledr_o[6]` = 1, display unchanged. Set `sw_i[9]` = 1: the flag clears on the next edge after registration.
- Simultaneous press when full: count stays 8, `ovf` stays 0, the oldest entry is displayed. Simultaneous press when empty: count = 1, `udf` = 1.
- `rst_i` pulse with 5 entries stored: `ledr_o` = 10'h100. A subsequent pop sets `udf` and displays 00. With `KEY_DEBOUNCE_EN`, a 2-cycle key glitch (`DEBOUNCE_CYCLES` = 4) causes no push.
